// File: rtl/onl_r4_pkg.sv
// Shared defaults and types for the radix-4 online adder stream checker.
// Digits are signed two's complement, MSD first on every stream.
package onl_r4_pkg;
  localparam int N_DEF   = 6;
  localparam int C_DEF   = 3;
  localparam int TMO_DEF = 16;

  typedef logic signed [C_DEF-1:0] digit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;
endpackage

// File: rtl/digit_shreg.sv
// Parallel-load shift register that presents one digit per shift, MSD first,
// and fills with zero digits behind the last real one.
module digit_shreg
  import onl_r4_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic [N*C-1:0] din,
  output logic [C-1:0]   dout
);
  logic [N*C-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[N*C-C-1:0], {C{1'b0}}};
    end
  end

  assign dout = sr[N*C-1 -: C];
endmodule

// File: rtl/online_stream_check_r4.sv
// Feeds two radix-4 signed-digit operands serially to an online adder and
// checks its MSD-first result stream against an expected sum, with a timeout.
module online_stream_check_r4
  import onl_r4_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int C   = C_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*C-1:0]         x,
  input  logic [N*C-1:0]         y,
  input  logic [(N+1)*C-1:0]     z_exp,
  output logic [C-1:0]           xd,
  output logic [C-1:0]           yd,
  output logic                   d_valid,
  input  logic [C-1:0]           zd,
  input  logic                   zd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [$clog2(N+2)-1:0] err_cnt,
  output logic [$clog2(N+1)-1:0] err_first,
  output state_t                 fsm_state
);
  localparam int EW = $clog2(N+2);
  localparam int FW = $clog2(N+1);
  localparam int TW = $clog2(TMO+1);
  localparam int ZW = (N+1)*C;

  // Handshake: xd/yd are consumed every cycle d_valid=1 (no backpressure);
  // zd is taken every cycle zd_valid=1 while busy, otherwise dropped.

  state_t          state, state_next;
  logic [ZW-1:0]   z_sr;
  logic [TW-1:0]   cyc_cnt;
  logic [FW-1:0]   feed_cnt;
  logic [EW-1:0]   rcv_cnt;
  logic [EW-1:0]   err_cnt_next;
  logic [C-1:0]    x_dig, y_dig, exp_dig;
  logic            accept, zd_hit, mismatch, last_digit, tmo_hit;

  digit_shreg #(.N(N), .C(C)) u_x_sr (
    .clk(clk), .rst(rst), .load(accept), .shift(state == S_FEED),
    .din(x), .dout(x_dig)
  );

  digit_shreg #(.N(N), .C(C)) u_y_sr (
    .clk(clk), .rst(rst), .load(accept), .shift(state == S_FEED),
    .din(y), .dout(y_dig)
  );

  always_comb begin
    busy         = (state == S_FEED) || (state == S_FLUSH);
    accept       = start && !busy;
    exp_dig      = z_sr[ZW-1 -: C];
    zd_hit       = zd_valid && busy;
    mismatch     = zd_hit && (zd != exp_dig);
    last_digit   = zd_hit && (rcv_cnt == EW'(N));
    // A final digit on the timeout cycle still completes the test.
    tmo_hit      = busy && ((cyc_cnt + TW'(1)) == TW'(TMO));
    err_cnt_next = err_cnt + EW'(mismatch);
    state_next   = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_next = S_FEED;
      S_FEED: begin
        if (last_digit || tmo_hit)         state_next = S_DONE;
        else if (feed_cnt == FW'(N-1))     state_next = S_FLUSH;
      end
      S_FLUSH: if (last_digit || tmo_hit) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    d_valid   = busy;
    xd        = (state == S_FEED) ? x_dig : '0;
    yd        = (state == S_FEED) ? y_dig : '0;
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      z_sr      <= '0;
      cyc_cnt   <= '0;
      feed_cnt  <= '0;
      rcv_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      err_first <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        z_sr      <= z_exp;
        cyc_cnt   <= '0;
        feed_cnt  <= '0;
        rcv_cnt   <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
        err_cnt   <= '0;
        err_first <= '0;
      end else if (busy) begin
        cyc_cnt <= cyc_cnt + TW'(1);
        if (state == S_FEED) feed_cnt <= feed_cnt + FW'(1);
        if (zd_hit) begin
          rcv_cnt <= rcv_cnt + EW'(1);
          z_sr    <= {z_sr[ZW-C-1:0], {C{1'b0}}};
          err_cnt <= err_cnt_next;
          if (mismatch && (err_cnt == '0)) err_first <= FW'(rcv_cnt);
        end
        if (state_next == S_DONE) begin
          done    <= 1'b1;
          timeout <= !last_digit;
          pass    <= last_digit && (err_cnt_next == '0);
        end
      end
    end
  end
endmodule
